// File: rtl/prio_encoder_4x2.sv
// 4-to-2 priority encoder with an any-request flag.
// Bit 3 of the request vector has the highest priority. The outputs are
// either registered (one cycle of latency) or purely combinational,
// selected by REG_OUT.
module prio_encoder_4x2 #(
  parameter bit REG_OUT = 1'b1
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [3:0] y,
  output logic [1:0] a,
  output logic       valid
);

  logic [1:0] a_d;
  logic       valid_d;

  // Encode the highest-numbered asserted request bit. All-zero input gives index 0 with valid low.
  always_comb begin
    a_d     = 2'd0;
    valid_d = 1'b0;
    casez (y)
      4'b1???: begin a_d = 2'd3; valid_d = 1'b1; end
      4'b01??: begin a_d = 2'd2; valid_d = 1'b1; end
      4'b001?: begin a_d = 2'd1; valid_d = 1'b1; end
      4'b0001: begin a_d = 2'd0; valid_d = 1'b1; end
      default: begin a_d = 2'd0; valid_d = 1'b0; end
    endcase
  end

  generate
    if (REG_OUT) begin : g_reg
      logic [1:0] a_q;
      logic       valid_q;

      // Output registers load every edge. Reset clears them immediately, without waiting for clk.
      always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
          a_q     <= 2'd0;
          valid_q <= 1'b0;
        end else begin
          a_q     <= a_d;
          valid_q <= valid_d;
        end
      end

      assign a     = a_q;
      assign valid = valid_q;
    end else begin : g_comb
      // In the combinational build the clock and reset are intentionally left unused.
      logic unused_clk_rst;
      assign unused_clk_rst = clk ^ rst;

      assign a     = a_d;
      assign valid = valid_d;
    end
  endgenerate

endmodule

// File: tb/tb_prio_encoder_4x2.sv
// Directed bench for prio_encoder_4x2. It checks the registered build and the combinational build.
module tb_prio_encoder_4x2;

  logic       clk;
  logic       rst;
  logic [3:0] y;
  logic [1:0] a_r;
  logic       valid_r;
  logic [1:0] a_c;
  logic       valid_c;

  int n_cmp;
  int n_bad;

  prio_encoder_4x2 #(.REG_OUT(1'b1)) dut_r (
    .clk   (clk),
    .rst   (rst),
    .y     (y),
    .a     (a_r),
    .valid (valid_r)
  );

  prio_encoder_4x2 #(.REG_OUT(1'b0)) dut_c (
    .clk   (clk),
    .rst   (rst),
    .y     (y),
    .a     (a_c),
    .valid (valid_c)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Apply y, let one rising edge pass, then compare the registered outputs 1 time unit later.
  task automatic edge_check(input string name, input logic [3:0] v,
                            input logic [1:0] exp_a, input logic exp_v);
    y = v;
    @(posedge clk);
    #1;
    n_cmp++;
    if ({a_r, valid_r} !== {exp_a, exp_v}) begin
      n_bad++;
      $display("FAIL %s y=%b: got a=%0d valid=%b, expected a=%0d valid=%b",
               name, v, a_r, valid_r, exp_a, exp_v);
    end else begin
      $display("ok   %s y=%b: a=%0d valid=%b", name, v, a_r, valid_r);
    end
  endtask

  task automatic test_reset;
    y   = 4'b1111;
    rst = 1'b0;
    #2;
    rst = 1'b1;             // asserted between edges; no clock edge follows before the check
    #1;
    n_cmp++;
    if ({a_r, valid_r} !== 3'b000) begin
      n_bad++;
      $display("FAIL reset_async: got a=%0d valid=%b, expected a=0 valid=0", a_r, valid_r);
    end else $display("ok   reset_async: a=0 valid=0");
    rst = 1'b0;
    edge_check("reset_release", 4'b1111, 2'd3, 1'b1);
  endtask

  task automatic test_single_hot;
    logic [3:0] vec [4];
    vec[0] = 4'b0001; vec[1] = 4'b0010; vec[2] = 4'b0100; vec[3] = 4'b1000;
    for (int i = 0; i < 4; i++) edge_check("single_hot", vec[i], 2'(i), 1'b1);
  endtask

  task automatic test_priority;
    edge_check("prio", 4'b0110, 2'd2, 1'b1);
    edge_check("prio", 4'b1010, 2'd3, 1'b1);
    edge_check("prio", 4'b0011, 2'd1, 1'b1);
    edge_check("prio", 4'b1111, 2'd3, 1'b1);
  endtask

  task automatic test_zero;
    edge_check("zero", 4'b0000, 2'd0, 1'b0);
    edge_check("zero_vs_one", 4'b0001, 2'd0, 1'b1);
    edge_check("zero_again", 4'b0000, 2'd0, 1'b0);
  endtask

  task automatic test_latency;
    edge_check("latency_load", 4'b0100, 2'd2, 1'b1);
    y = 4'b0001;            // changed between edges; registered outputs must hold
    #3;
    n_cmp++;
    if ({a_r, valid_r} !== {2'd2, 1'b1}) begin
      n_bad++;
      $display("FAIL latency_hold: got a=%0d valid=%b, expected a=2 valid=1", a_r, valid_r);
    end else $display("ok   latency_hold: a=2 valid=1");
    y = 4'b0000;
    #1;
    n_cmp++;
    if ({a_r, valid_r} !== {2'd2, 1'b1}) begin
      n_bad++;
      $display("FAIL latency_hold2: got a=%0d valid=%b, expected a=2 valid=1", a_r, valid_r);
    end else $display("ok   latency_hold2: a=2 valid=1");
    edge_check("latency_next", 4'b0010, 2'd1, 1'b1);
  endtask

  task automatic test_reset_mid;
    edge_check("mid_sweep", 4'b0100, 2'd2, 1'b1);
    edge_check("mid_sweep", 4'b1000, 2'd3, 1'b1);
    rst = 1'b1;
    #1;
    n_cmp++;
    if ({a_r, valid_r} !== 3'b000) begin
      n_bad++;
      $display("FAIL mid_reset: got a=%0d valid=%b, expected a=0 valid=0", a_r, valid_r);
    end else $display("ok   mid_reset: a=0 valid=0");
    rst = 1'b0;
    #1;
    n_cmp++;
    if ({a_r, valid_r} !== 3'b000) begin
      n_bad++;
      $display("FAIL mid_reset_hold: got a=%0d valid=%b, expected a=0 valid=0", a_r, valid_r);
    end else $display("ok   mid_reset_hold: a=0 valid=0");
    edge_check("mid_resume", 4'b1000, 2'd3, 1'b1);
  endtask

  task automatic test_comb;
    logic [3:0] vy [6];
    logic [2:0] ve [6];     // {a, valid}
    vy[0] = 4'b0000; ve[0] = 3'b000;
    vy[1] = 4'b0001; ve[1] = 3'b001;
    vy[2] = 4'b0011; ve[2] = 3'b011;
    vy[3] = 4'b0110; ve[3] = 3'b101;
    vy[4] = 4'b1010; ve[4] = 3'b111;
    vy[5] = 4'b0100; ve[5] = 3'b101;
    for (int i = 0; i < 6; i++) begin
      y = vy[i];
      #1;
      n_cmp++;
      if ({a_c, valid_c} !== ve[i]) begin
        n_bad++;
        $display("FAIL comb y=%b: got a=%0d valid=%b, expected a=%0d valid=%b",
                 vy[i], a_c, valid_c, ve[i][2:1], ve[i][0]);
      end else $display("ok   comb y=%b: a=%0d valid=%b", vy[i], a_c, valid_c);
    end
  endtask

  initial begin
    n_cmp = 0;
    n_bad = 0;
    rst   = 1'b0;
    y     = 4'b0000;
    test_reset();
    test_single_hot();
    test_priority();
    test_zero();
    test_latency();
    test_reset_mid();
    test_comb();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
